// File: rtl/sokoban_move_ctrl.sv
// Sokoban move sequencer: executes one player move against the single-port
// map RAM (read ahead, decide walk/push/block, write back far/near/old).
module sokoban_move_ctrl #(
    parameter int COLS         = 10,
    parameter int ROWS         = 8,
    parameter int START_X      = 1,
    parameter int START_Y      = 3,
    parameter int NUM_GOALS    = 4,
    parameter int INIT_ON_GOAL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [6:0]  mem_addr,
    output logic        mem_rd_en,
    input  logic [2:0]  mem_rdata,
    output logic        mem_we,
    output logic [2:0]  mem_wdata,
    output logic [3:0]  player_x,
    output logic [2:0]  player_y,
    output logic [2:0]  boxes_on_goal,
    output logic        solved,
    output logic [15:0] move_count,
    output logic        done,
    output logic        moved
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD_NEAR,
        S_RD_FAR,
        S_WR_FAR,
        S_WR_NEAR,
        S_WR_OLD,
        S_DONE
    } state_t;

    localparam logic [2:0] CODE_ROAD        = 3'd0;
    localparam logic [2:0] CODE_PLAYER      = 3'd2;
    localparam logic [2:0] CODE_BOX         = 3'd3;
    localparam logic [2:0] CODE_GOAL        = 3'd4;
    localparam logic [2:0] CODE_BOX_GOAL    = 3'd5;
    localparam logic [2:0] CODE_PLAYER_GOAL = 3'd6;

    localparam logic signed [5:0] COLS_S = 6'(COLS);
    localparam logic signed [5:0] ROWS_S = 6'(ROWS);

    // move_valid/move_ready: a command is taken on a rising edge where both
    // are high; move_valid while busy is dropped, never queued.

    state_t      state_q, state_d;
    logic [3:0]  player_x_q, player_x_d;
    logic [2:0]  player_y_q, player_y_d;
    logic        on_goal_q, on_goal_d;
    logic [2:0]  boxes_on_goal_q, boxes_on_goal_d;
    logic [15:0] move_count_q, move_count_d;
    logic [3:0]  near_x_q, near_x_d;
    logic [2:0]  near_y_q, near_y_d;
    logic [3:0]  far_x_q, far_x_d;
    logic [2:0]  far_y_q, far_y_d;
    logic        far_in_q, far_in_d;
    logic [2:0]  near_code_q, near_code_d;
    logic [2:0]  far_code_q, far_code_d;
    logic        moved_q, moved_d;

    logic signed [5:0] step_x, step_y;
    logic signed [5:0] near_x_s, near_y_s, far_x_s, far_y_s;
    logic              near_in, far_in;
    logic              near_goal;

    function automatic logic [6:0] cell_addr(input logic [3:0] x, input logic [2:0] y);
        return 7'((32'(y) * COLS) + 32'(x));
    endfunction

    function automatic logic is_free(input logic [2:0] code);
        return (code == CODE_ROAD) || (code == CODE_GOAL);
    endfunction

    function automatic logic is_box(input logic [2:0] code);
        return (code == CODE_BOX) || (code == CODE_BOX_GOAL);
    endfunction

    // Signed one- and two-step targets so that x-1 at column 0 reads as -1.
    always_comb begin
        step_x = 6'sd0;
        step_y = 6'sd0;
        case (move_dir)
            2'd0:    step_y = -6'sd1;
            2'd1:    step_y = 6'sd1;
            2'd2:    step_x = -6'sd1;
            default: step_x = 6'sd1;
        endcase
        near_x_s = $signed({2'b00, player_x_q}) + step_x;
        near_y_s = $signed({3'b000, player_y_q}) + step_y;
        far_x_s  = near_x_s + step_x;
        far_y_s  = near_y_s + step_y;
        near_in  = (near_x_s >= 6'sd0) && (near_x_s < COLS_S) &&
                   (near_y_s >= 6'sd0) && (near_y_s < ROWS_S);
        far_in   = (far_x_s >= 6'sd0) && (far_x_s < COLS_S) &&
                   (far_y_s >= 6'sd0) && (far_y_s < ROWS_S);
    end

    assign near_goal = (near_code_q == CODE_GOAL) || (near_code_q == CODE_BOX_GOAL);

    always_comb begin
        state_d         = state_q;
        player_x_d      = player_x_q;
        player_y_d      = player_y_q;
        on_goal_d       = on_goal_q;
        boxes_on_goal_d = boxes_on_goal_q;
        move_count_d    = move_count_q;
        near_x_d        = near_x_q;
        near_y_d        = near_y_q;
        far_x_d         = far_x_q;
        far_y_d         = far_y_q;
        far_in_d        = far_in_q;
        near_code_d     = near_code_q;
        far_code_d      = far_code_q;
        moved_d         = moved_q;

        move_ready = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = 7'd0;
        mem_rd_en  = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 3'd0;
        done       = 1'b0;
        moved      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                move_ready = 1'b1;
                if (move_valid) begin
                    near_x_d = near_x_s[3:0];
                    near_y_d = near_y_s[2:0];
                    far_x_d  = far_x_s[3:0];
                    far_y_d  = far_y_s[2:0];
                    far_in_d = far_in;
                    moved_d  = 1'b0;
                    state_d  = near_in ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = cell_addr(near_x_q, near_y_q);
                    state_d   = S_RD_NEAR;
                end
            end
            S_RD_NEAR: begin
                mem_req     = 1'b1;
                near_code_d = mem_rdata;
                if (is_free(mem_rdata)) begin
                    state_d = S_WR_NEAR;
                end else if (is_box(mem_rdata) && far_in_q) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = cell_addr(far_x_q, far_y_q);
                    state_d   = S_RD_FAR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_RD_FAR: begin
                mem_req    = 1'b1;
                far_code_d = mem_rdata;
                state_d    = is_free(mem_rdata) ? S_WR_FAR : S_DONE;
            end
            S_WR_FAR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cell_addr(far_x_q, far_y_q);
                mem_wdata = (far_code_q == CODE_GOAL) ? CODE_BOX_GOAL : CODE_BOX;
                state_d   = S_WR_NEAR;
            end
            S_WR_NEAR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cell_addr(near_x_q, near_y_q);
                mem_wdata = near_goal ? CODE_PLAYER_GOAL : CODE_PLAYER;
                state_d   = S_WR_OLD;
            end
            S_WR_OLD: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = cell_addr(player_x_q, player_y_q);
                mem_wdata  = on_goal_q ? CODE_GOAL : CODE_ROAD;
                player_x_d = near_x_q;
                player_y_d = near_y_q;
                on_goal_d  = near_goal;
                moved_d    = 1'b1;
                if (move_count_q != 16'hFFFF) begin
                    move_count_d = move_count_q + 16'd1;
                end
                // Only a push changes the goal tally; far_code_q is stale on walks
                // but near_code_q is then road/goal, so neither arm fires.
                if ((near_code_q == CODE_BOX) && (far_code_q == CODE_GOAL)) begin
                    boxes_on_goal_d = boxes_on_goal_q + 3'd1;
                end else if ((near_code_q == CODE_BOX_GOAL) && (far_code_q == CODE_ROAD)) begin
                    boxes_on_goal_d = boxes_on_goal_q - 3'd1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                moved   = moved_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            player_x_q      <= 4'(START_X);
            player_y_q      <= 3'(START_Y);
            on_goal_q       <= 1'b0;
            boxes_on_goal_q <= 3'(INIT_ON_GOAL);
            move_count_q    <= 16'd0;
            near_x_q        <= 4'd0;
            near_y_q        <= 3'd0;
            far_x_q         <= 4'd0;
            far_y_q         <= 3'd0;
            far_in_q        <= 1'b0;
            near_code_q     <= 3'd0;
            far_code_q      <= 3'd0;
            moved_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            player_x_q      <= player_x_d;
            player_y_q      <= player_y_d;
            on_goal_q       <= on_goal_d;
            boxes_on_goal_q <= boxes_on_goal_d;
            move_count_q    <= move_count_d;
            near_x_q        <= near_x_d;
            near_y_q        <= near_y_d;
            far_x_q         <= far_x_d;
            far_y_q         <= far_y_d;
            far_in_q        <= far_in_d;
            near_code_q     <= near_code_d;
            far_code_q      <= far_code_d;
            moved_q         <= moved_d;
        end
    end

    assign player_x      = player_x_q;
    assign player_y      = player_y_q;
    assign boxes_on_goal = boxes_on_goal_q;
    assign move_count    = move_count_q;
    assign solved        = (boxes_on_goal_q == 3'(NUM_GOALS));

endmodule

// File: tb/tb_sokoban_move_ctrl.sv
// Bench for sokoban_move_ctrl: behavioural map RAM, a grid-level move model
// and per-scenario tasks comparing writes, latency and status outputs.
module tb_sokoban_move_ctrl;
  localparam int COLS      = 10;
  localparam int ROWS      = 8;
  localparam int NUM_GOALS = 4;
  localparam int NCELL     = COLS * ROWS;

  logic        clk;
  logic        rst;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        move_ready;
  logic        mem_req;
  logic        mem_gnt;
  logic [6:0]  mem_addr;
  logic        mem_rd_en;
  logic [2:0]  mem_rdata;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic [3:0]  player_x;
  logic [2:0]  player_y;
  logic [2:0]  boxes_on_goal;
  logic        solved;
  logic [15:0] move_count;
  logic        done;
  logic        moved;

  int errors;
  int checks;

  sokoban_move_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .START_X(1), .START_Y(3),
    .NUM_GOALS(NUM_GOALS), .INIT_ON_GOAL(0)
  ) dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_dir(move_dir),
    .move_ready(move_ready), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .player_x(player_x),
    .player_y(player_y), .boxes_on_goal(boxes_on_goal), .solved(solved),
    .move_count(move_count), .done(done), .moved(moved)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- map RAM (environment) ----------------
  logic [2:0] ram [128];
  logic [2:0] ld_img [128];
  logic       ld_en;

  always @(posedge clk) begin
    if (ld_en) begin
      ram <= ld_img;
    end else begin
      if (mem_rd_en) mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  // ---------------- reference model ----------------
  logic [2:0] ref_map [NCELL];
  int ref_px;
  int ref_py;
  int ref_count;
  logic [9:0] exp_q[$];

  function automatic bit in_map(input int x, input int y);
    return (x >= 0) && (x < COLS) && (y >= 0) && (y < ROWS);
  endfunction

  function automatic int ref_boxes();
    int n;
    n = 0;
    for (int i = 0; i < NCELL; i++) if (ref_map[i] == 3'd5) n++;
    return n;
  endfunction

  // Applies a move to the grid; returns done latency, moved flag, read count
  // and fills exp_q with the ordered (addr,data) writes.
  task automatic model_move(input int dir, output int lat, output bit mv, output int rd);
    int dx, dy, nx, ny, fx, fy, near_a, far_a, old_a;
    logic [2:0] nc, fc;
    dx = 0; dy = 0;
    case (dir)
      0: dy = -1;
      1: dy = 1;
      2: dx = -1;
      default: dx = 1;
    endcase
    nx = ref_px + dx; ny = ref_py + dy;
    fx = nx + dx;     fy = ny + dy;
    exp_q.delete();
    mv = 1'b0; lat = 1; rd = 0;
    if (!in_map(nx, ny)) return;
    near_a = ny * COLS + nx;
    old_a  = ref_py * COLS + ref_px;
    nc = ref_map[near_a];
    rd = 1;
    if (nc == 3'd0 || nc == 3'd4) begin
      lat = 5;
    end else if (nc == 3'd3 || nc == 3'd5) begin
      lat = 3;
      if (!in_map(fx, fy)) return;
      far_a = fy * COLS + fx;
      fc = ref_map[far_a];
      rd = 2;
      lat = 4;
      if (!(fc == 3'd0 || fc == 3'd4)) return;
      lat = 7;
      ref_map[far_a] = (fc == 3'd4) ? 3'd5 : 3'd3;
      exp_q.push_back({7'(far_a), ref_map[far_a]});
    end else begin
      lat = 3;
      return;
    end
    ref_map[near_a] = (nc == 3'd4 || nc == 3'd5) ? 3'd6 : 3'd2;
    exp_q.push_back({7'(near_a), ref_map[near_a]});
    ref_map[old_a] = (ref_map[old_a] == 3'd6) ? 3'd4 : 3'd0;
    exp_q.push_back({7'(old_a), ref_map[old_a]});
    ref_px = nx; ref_py = ny;
    if (ref_count < 65535) ref_count++;
    mv = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_and_reset();
    for (int i = 0; i < 128; i++) ld_img[i] = (i < NCELL) ? ref_map[i] : 3'd1;
    ref_px = 1; ref_py = 3; ref_count = 0;
    @(negedge clk);
    rst = 1'b1; move_valid = 1'b0; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic build_map_a();
    for (int i = 0; i < NCELL; i++) ref_map[i] = 3'd0;
    ref_map[3*COLS+1] = 3'd2;
    ref_map[2*COLS+3] = 3'd3;
    ref_map[2*COLS+4] = 3'd4;
    ref_map[4*COLS+4] = 3'd1;
    ref_map[3*COLS+5] = 3'd3;
    ref_map[3*COLS+6] = 3'd3;
    ref_map[3*COLS+3] = 3'd7;
    ref_map[0*COLS+9] = 3'd3;
  endtask

  task automatic do_move(input int dir, input string tag);
    int lat, exp_rd, done_cyc, rd_got;
    bit mv, mv_got;
    logic [9:0] got_q[$];
    logic [9:0] act;
    model_move(dir, lat, mv, exp_rd);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir = 2'(dir);
    done_cyc = 0; rd_got = 0; mv_got = 1'b0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        move_valid = 1'b0;
        checks++;
        if (move_ready !== 1'b0) begin
          errors++; $display("FAIL %s busy_ready: got %b expected 0", tag, move_ready);
        end
      end
      if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
      if (mem_rd_en === 1'b1) rd_got++;
      if (done === 1'b1) begin
        done_cyc = c;
        mv_got = moved;
        checks++;
        if (mem_req !== 1'b0) begin
          errors++; $display("FAIL %s req_at_done: got %b expected 0", tag, mem_req);
        end
      end
    end
    checks++;
    if (done_cyc != lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d (0 = timeout)", tag, done_cyc, lat);
    end
    checks++;
    if (mv_got !== mv) begin
      errors++; $display("FAIL %s moved: got %b expected %b", tag, mv_got, mv);
    end
    checks++;
    if (rd_got != exp_rd) begin
      errors++; $display("FAIL %s reads: got %0d expected %0d", tag, rd_got, exp_rd);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s write_count: got %0d expected %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < got_q.size()) ? got_q[i] : 10'bx;
      checks++;
      if (act !== exp_q[i]) begin
        errors++;
        $display("FAIL %s write%0d: got addr %0d code %0d expected addr %0d code %0d",
                 tag, i, act[9:3], act[2:0], exp_q[i][9:3], exp_q[i][2:0]);
      end
    end
    checks++;
    if (player_x !== 4'(ref_px) || player_y !== 3'(ref_py)) begin
      errors++; $display("FAIL %s position: got (%0d,%0d) expected (%0d,%0d)", tag, player_x, player_y, ref_px, ref_py);
    end
    checks++;
    if (move_count !== 16'(ref_count)) begin
      errors++; $display("FAIL %s move_count: got %0d expected %0d", tag, move_count, ref_count);
    end
    checks++;
    if (boxes_on_goal !== 3'(ref_boxes())) begin
      errors++; $display("FAIL %s boxes_on_goal: got %0d expected %0d", tag, boxes_on_goal, ref_boxes());
    end
    checks++;
    if (solved !== (ref_boxes() == NUM_GOALS)) begin
      errors++; $display("FAIL %s solved: got %b expected %b", tag, solved, ref_boxes() == NUM_GOALS);
    end
    @(posedge clk);
    #1;
    checks++;
    if (move_ready !== 1'b1 || done !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: got ready=%b done=%b req=%b expected 1 0 0", tag, move_ready, done, mem_req);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    build_map_a();
    load_and_reset();
    checks++;
    if (player_x !== 4'd1 || player_y !== 3'd3) begin
      errors++; $display("FAIL reset_pos: got (%0d,%0d) expected (1,3)", player_x, player_y);
    end
    checks++;
    if (move_count !== 16'd0 || boxes_on_goal !== 3'd0 || solved !== 1'b0) begin
      errors++; $display("FAIL reset_counters: got count=%0d boxes=%0d solved=%b expected 0 0 0", move_count, boxes_on_goal, solved);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_rd_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 7'd0 || mem_wdata !== 3'd0) begin
      errors++; $display("FAIL reset_mem: got req=%b rd=%b we=%b addr=%0d wdata=%0d expected all 0", mem_req, mem_rd_en, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (done !== 1'b0 || moved !== 1'b0 || move_ready !== 1'b1) begin
      errors++; $display("FAIL reset_status: got done=%b moved=%b ready=%b expected 0 0 1", done, moved, move_ready);
    end
  endtask

  task automatic test_walk();
    do_move(0, "walk_up");
  endtask

  task automatic test_push_goal();
    do_move(3, "walk_right");
    do_move(3, "push_onto_goal");
  endtask

  task automatic test_push_off_goal();
    do_move(3, "push_off_goal");
    do_move(1, "leave_goal");
  endtask

  task automatic test_blocked();
    do_move(1, "blocked_wall");
    do_move(3, "blocked_box_box");
    do_move(2, "blocked_code7");
  endtask

  task automatic test_edges();
    do_move(0, "walk_onto_goal");
    do_move(0, "walk_off_goal");
    do_move(0, "walk_row0");
    do_move(0, "out_of_range_up");
    for (int i = 0; i < 4; i++) do_move(3, "walk_row0_right");
    do_move(3, "box_far_out_of_range");
  endtask

  task automatic test_grant_wait();
    int lat, exp_rd, done_cyc, rd_got, bad;
    bit mv;
    logic [9:0] got_q[$];
    logic [9:0] act;
    model_move(1, lat, mv, exp_rd);
    mem_gnt = 1'b0;
    @(negedge clk);
    move_valid = 1'b1;
    move_dir = 2'd1;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_req !== 1'b1 || mem_rd_en !== 1'b0 || mem_we !== 1'b0 || move_ready !== 1'b0 || done !== 1'b0) bad++;
      if (c == 5 || c == 11) begin
        move_valid = 1'b1; move_dir = 2'd0;
      end else begin
        move_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL grant_wait_hold: got %0d bad cycles expected 0", bad);
    end
    mem_gnt = 1'b1;
    #1;
    rd_got = (mem_rd_en === 1'b1) ? 1 : 0;
    done_cyc = 0;
    for (int c = 22; c <= 60 && done_cyc == 0; c++) begin
      @(posedge clk);
      #1;
      if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
      if (mem_rd_en === 1'b1) rd_got++;
      if (done === 1'b1) done_cyc = c;
    end
    checks++;
    if (done_cyc != 25 || moved !== mv) begin
      errors++; $display("FAIL grant_wait_done: got cycle %0d moved %b expected 25 %b", done_cyc, moved, mv);
    end
    checks++;
    if (rd_got != exp_rd || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL grant_wait_access: got rd=%0d wr=%0d expected rd=%0d wr=%0d", rd_got, got_q.size(), exp_rd, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < got_q.size()) ? got_q[i] : 10'bx;
      checks++;
      if (act !== exp_q[i]) begin
        errors++; $display("FAIL grant_wait_write%0d: got %h expected %h", i, act, exp_q[i]);
      end
    end
    checks++;
    if (move_count !== 16'(ref_count) || player_y !== 3'(ref_py)) begin
      errors++; $display("FAIL grant_wait_state: got count=%0d y=%0d expected %0d %0d", move_count, player_y, ref_count, ref_py);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (move_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL grant_wait_no_queue: got ready=%b req=%b expected 1 0", move_ready, mem_req);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    move_valid = 1'b1;
    move_dir = 2'd1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) move_valid = 1'b0;
    end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 7'(2*COLS+8) || mem_wdata !== 3'd2) begin
      errors++; $display("FAIL reset_mid_wr_near: got we=%b addr=%0d wdata=%0d expected 1 %0d 2", mem_we, mem_addr, mem_wdata, 2*COLS+8);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (player_x !== 4'd1 || player_y !== 3'd3 || move_count !== 16'd0 || boxes_on_goal !== 3'd0) begin
      errors++; $display("FAIL reset_mid_regs: got (%0d,%0d) count=%0d boxes=%0d expected (1,3) 0 0", player_x, player_y, move_count, boxes_on_goal);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_rd_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 7'd0 || mem_wdata !== 3'd0 ||
        done !== 1'b0 || moved !== 1'b0 || move_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_outputs: got req=%b rd=%b we=%b addr=%0d wd=%0d done=%b moved=%b ready=%b",
                         mem_req, mem_rd_en, mem_we, mem_addr, mem_wdata, done, moved, move_ready);
    end
  endtask

  task automatic test_solved();
    for (int i = 0; i < NCELL; i++) ref_map[i] = 3'd0;
    ref_map[3*COLS+1] = 3'd2;
    ref_map[2*COLS+1] = 3'd3; ref_map[1*COLS+1] = 3'd4;
    ref_map[4*COLS+1] = 3'd3; ref_map[5*COLS+1] = 3'd4;
    ref_map[3*COLS+2] = 3'd3; ref_map[3*COLS+3] = 3'd4;
    ref_map[4*COLS+3] = 3'd3; ref_map[4*COLS+4] = 3'd4;
    load_and_reset();
    do_move(0, "solve_push1");
    do_move(1, "solve_walk1");
    do_move(1, "solve_push2");
    do_move(0, "solve_walk2");
    do_move(3, "solve_push3");
    do_move(1, "solve_walk3");
    checks++;
    if (solved !== 1'b0) begin
      errors++; $display("FAIL solved_early: got %b expected 0", solved);
    end
    do_move(3, "solve_push4");
    checks++;
    if (solved !== 1'b1 || boxes_on_goal !== 3'd4) begin
      errors++; $display("FAIL solved_final: got solved=%b boxes=%0d expected 1 4", solved, boxes_on_goal);
    end
  endtask

  task automatic test_back_to_back();
    int r, placed, bad;
    for (int i = 0; i < NCELL; i++) begin
      r = $urandom_range(0, 99);
      ref_map[i] = (r < 60) ? 3'd0 : (r < 72) ? 3'd1 : (r < 90) ? 3'd3 : (r < 95) ? 3'd7 : 3'd0;
    end
    ref_map[3*COLS+1] = 3'd2;
    placed = 0;
    for (int t = 0; t < 1000 && placed < NUM_GOALS; t++) begin
      r = $urandom_range(0, NCELL - 1);
      if (r != 3*COLS+1 && ref_map[r] == 3'd0) begin
        ref_map[r] = 3'd4;
        placed++;
      end
    end
    load_and_reset();
    for (int m = 0; m < 150; m++) do_move($urandom_range(0, 3), "random");
    bad = 0;
    for (int i = 0; i < NCELL; i++) if (ram[i] !== ref_map[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL random_map_image: got %0d differing cells expected 0", bad);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; move_valid = 1'b0; move_dir = 2'd0; mem_gnt = 1'b1; ld_en = 1'b0;
    test_reset();
    test_walk();
    test_push_goal();
    test_push_off_goal();
    test_blocked();
    test_edges();
    test_grant_wait();
    test_reset_mid();
    test_solved();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sokoban_move_ctrl.md
# sokoban_move_ctrl

Sequencer that executes one player move at a time against the single-port map RAM of the Sokoban game. It accepts a direction command from the debounced button logic and requests the map port from the VGA/map arbiter. It reads the cells ahead of the player, decides walk/push/block, then writes the updated cells back. It also maintains player position, boxes-on-goal count, move count and the solved flag used by the seven-segment display.

## Interface
- COLS, 10, map width in cells; cell address = y*COLS + x
- ROWS, 8, map height in cells
- START_X, 1, player x after reset
- START_Y, 3, player y after reset
- NUM_GOALS, 4, number of goal cells; solved when this many boxes are on goals
- INIT_ON_GOAL, 0, boxes already on goals in the reset map image

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- move_valid  in  1  move request
- move_dir  in  2  0 up (y-1), 1 down (y+1), 2 left (x-1), 3 right (x+1)
- move_ready  out  1  high only in IDLE
- mem_req  out  1  map port request to arbiter
- mem_gnt  in  1  map port grant
- mem_addr  out  7  cell address
- mem_rd_en  out  1  read strobe; mem_rdata valid next cycle
- mem_rdata  in  3  cell code
- mem_we  out  1  write strobe
- mem_wdata  out  3  cell code to write
- player_x  out  4  current x
- player_y  out  3  current y
- boxes_on_goal  out  3  boxes currently on goal cells
- solved  out  1  boxes_on_goal == NUM_GOALS
- move_count  out  16  successful moves, saturates at 16'hFFFF
- done  out  1  one-cycle pulse at end of every accepted command
- moved  out  1  valid with done; 1 = player position changed

## Operation
- Cell codes: 0 road, 1 wall, 2 player, 3 box, 4 goal, 5 box on goal, 6 player on goal, 7 treated as wall.
- Internal: dir_r, near (x1,y1) = player+1 step, far (x2,y2) = player+2 steps, on_goal_r (player stands on goal), near_code_r.
- FSM states: IDLE, REQ, RD_NEAR, RD_FAR, WR_FAR, WR_NEAR, WR_OLD, DONE.
- IDLE: move_ready=1. On move_valid, latch dir and compute near/far. If near is out of range (x<0, x≥COLS, y<0, y≥ROWS), go to DONE with moved=0 and make no memory access. Otherwise go to REQ.
- REQ: mem_req=1. In the cycle mem_gnt=1: mem_rd_en=1, mem_addr=near, go to RD_NEAR. Wait indefinitely otherwise.
- RD_NEAR: sample mem_rdata.
  - Code 0 or 4: go to WR_NEAR.
  - Code 3 or 5 with far in range: mem_rd_en=1, addr=far, go to RD_FAR.
  - Anything else: go to DONE with moved=0.
- RD_FAR: code 0 or 4 goes to WR_FAR; anything else goes to DONE with moved=0.
- WR_FAR: write 5 if far was 4, else 3.
- WR_NEAR: write 6 if near_code_r ∈ {4,5}, else 2.
- WR_OLD:
  - Write 4 at the old position if on_goal_r, else 0.
  - Update player_x/y to near and on_goal_r to (near_code_r ∈ {4,5}).
  - Increment move_count with saturation.
  - boxes_on_goal, for pushes only: +1 if near was 3 and far was 4; −1 if near was 5 and far was 0; unchanged otherwise.
- DONE: done=1, moved as decided, mem_req=0; return to IDLE.
- mem_req stays high continuously from REQ through WR_OLD. mem_gnt is sampled only in REQ; the arbiter holds grant while mem_req is high.
- move_valid outside IDLE is ignored and not queued.

## Timing
- Reset values:
  - player_x=START_X, player_y=START_Y, on_goal_r=0
  - boxes_on_goal=INIT_ON_GOAL, move_count=0
  - mem_req/mem_rd_en/mem_we/done/moved=0, mem_addr=0, mem_wdata=0, state IDLE
- rst mid-command: abort the sequence, return all outputs to reset values next cycle; no rollback of RAM contents.
- With grant already high, accept at cycle 0:
  - Walk: REQ 1, RD_NEAR 2, WR_NEAR 3, WR_OLD 4, DONE 5, ready at 6.
  - Push: 7 cycles, ready at 8.
  - Blocked at near: done at cycle 3. Out-of-range near: done at cycle 1.
- Each write is exactly one cycle with mem_we=1 and addr/wdata stable that cycle; writes are ordered far, near, old.
- solved is combinational from boxes_on_goal; it goes high the cycle after WR_OLD.

## Test plan
- Reset, player (1,3) on road, cell (1,2)=0, dir=0 with gnt=1 -> writes (1,2)=2 then (1,3)=0, player_y=2, move_count=1, done/moved=1 at cycle 5.
- Player (2,2), cell (3,2)=3, (4,2)=4, dir=3 -> writes (4,2)=5, (3,2)=2, (2,2)=0; boxes_on_goal 0→1, done at cycle 7.
- Push box code 5 onto road (far code 0) -> far=3, near=6, boxes_on_goal decrements; next move off that cell writes 4 behind the player.
- Near=1 (wall), or box with far=3 -> no mem_we at any cycle, done=1 with moved=0, move_count unchanged.
- Hold mem_gnt=0 for 20 cycles after accept -> mem_req high, no rd/we, move_valid pulses ignored; grant arrives and the move completes normally.
- Assert rst during WR_NEAR -> next cycle all outputs at reset values, state IDLE, move_ready=1; NUM_GOALS pushes onto goals -> solved=1.
